// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage: load extraction, fault detection,
// registered register-file write / forwarding bus and a retired-instruction counter.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             VALID_IN,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic [1:0]       CRT_WB_IN,
  input  logic [2:0]       FUNCT3_IN,
  input  logic [XLEN-1:0]  ALU_RESULT_IN,
  input  logic [XLEN-1:0]  READ_DATA_IN,
  input  logic [4:0]       INST_IN,
  output logic             REG_WRITE_OUT,
  output logic [4:0]       RD_OUT,
  output logic [XLEN-1:0]  WB_DATA_OUT,
  output logic             VALID_OUT,
  output logic             LOAD_FAULT_OUT,
  output logic [CNT_W-1:0] RETIRED_OUT
);

  logic [1:0]       off_s;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic [XLEN-1:0]  load_data_s;
  logic             bad_load_s;
  logic             fault_s;

  logic             valid_d, valid_q;
  logic             reg_write_d, reg_write_q;
  logic             load_fault_d, load_fault_q;
  logic [4:0]       rd_d, rd_q;
  logic [XLEN-1:0]  wb_data_d, wb_data_q;
  logic [CNT_W-1:0] retired_d, retired_q;

  assign off_s = ALU_RESULT_IN[1:0];

  // Lane selection and sign/zero extension of the raw memory word.
  always_comb begin
    case (off_s)
      2'd0:    byte_s = READ_DATA_IN[7:0];
      2'd1:    byte_s = READ_DATA_IN[15:8];
      2'd2:    byte_s = READ_DATA_IN[23:16];
      2'd3:    byte_s = READ_DATA_IN[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off_s[1]) begin
      half_s = READ_DATA_IN[31:16];
    end else begin
      half_s = READ_DATA_IN[15:0];
    end
    load_data_s = {XLEN{1'b0}};
    bad_load_s  = 1'b0;
    case (FUNCT3_IN)
      3'b000:  load_data_s = {{(XLEN-8){byte_s[7]}}, byte_s};
      3'b100:  load_data_s = {{(XLEN-8){1'b0}}, byte_s};
      3'b001: begin
        load_data_s = {{(XLEN-16){half_s[15]}}, half_s};
        bad_load_s  = off_s[0];
      end
      3'b101: begin
        load_data_s = {{(XLEN-16){1'b0}}, half_s};
        bad_load_s  = off_s[0];
      end
      3'b010: begin
        load_data_s = READ_DATA_IN;
        bad_load_s  = (off_s != 2'd0);
      end
      default: bad_load_s = 1'b1;
    endcase
  end

  // A fault only matters for a real load; a bubble never reports one.
  assign fault_s = VALID_IN & CRT_WB_IN[0] & bad_load_s;

  // Next-state selection: FLUSH beats STALL beats normal capture.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    load_fault_d = load_fault_q;
    rd_d         = rd_q;
    wb_data_d    = wb_data_q;
    retired_d    = retired_q;
    if (FLUSH) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      load_fault_d = 1'b0;
      rd_d         = 5'd0;
      wb_data_d    = {XLEN{1'b0}};
    end else if (STALL) begin
      retired_d = retired_q;
    end else begin
      valid_d      = VALID_IN;
      rd_d         = INST_IN;
      load_fault_d = fault_s;
      reg_write_d  = VALID_IN & CRT_WB_IN[1] & (INST_IN != 5'd0) & ~fault_s;
      if (!CRT_WB_IN[0]) begin
        wb_data_d = ALU_RESULT_IN;
      end else if (bad_load_s) begin
        wb_data_d = {XLEN{1'b0}};
      end else begin
        wb_data_d = load_data_s;
      end
      if (VALID_IN) begin
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_d = retired_q;
      end
    end
  end

  // Stage registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      load_fault_q <= 1'b0;
      rd_q         <= 5'd0;
      wb_data_q    <= {XLEN{1'b0}};
      retired_q    <= {CNT_W{1'b0}};
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      load_fault_q <= load_fault_d;
      rd_q         <= rd_d;
      wb_data_q    <= wb_data_d;
      retired_q    <= retired_d;
    end
  end

  assign VALID_OUT      = valid_q;
  assign REG_WRITE_OUT  = reg_write_q;
  assign LOAD_FAULT_OUT = load_fault_q;
  assign RD_OUT         = rd_q;
  assign WB_DATA_OUT    = wb_data_q;
  assign RETIRED_OUT    = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage against a behavioural reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, stall, flush;
  logic [1:0]  crt;
  logic [2:0]  f3;
  logic [31:0] alu, rdata;
  logic [4:0]  inst;
  logic        reg_write_out, valid_out, load_fault_out;
  logic [4:0]  rd_out;
  logic [31:0] wb_data_out;
  logic [63:0] retired_out;

  int compared = 0;
  int mismatched = 0;

  // Reference state.
  logic        m_valid, m_rw, m_fault, m_dc;
  logic [4:0]  m_rd;
  logic [31:0] m_wb;
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .VALID_IN(valid_in), .STALL(stall), .FLUSH(flush),
    .CRT_WB_IN(crt), .FUNCT3_IN(f3), .ALU_RESULT_IN(alu), .READ_DATA_IN(rdata),
    .INST_IN(inst), .REG_WRITE_OUT(reg_write_out), .RD_OUT(rd_out),
    .WB_DATA_OUT(wb_data_out), .VALID_OUT(valid_out),
    .LOAD_FAULT_OUT(load_fault_out), .RETIRED_OUT(retired_out)
  );

  // Load result from the ISA rules using shifts, masks and arithmetic.
  function automatic void ref_load(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] d, output logic [31:0] r,
                                   output bit flt);
    int unsigned off;
    logic [31:0] b, h;
    off = a % 4;
    b = (d >> (8 * off)) & 32'h0000_00FF;
    h = (d >> (8 * off)) & 32'h0000_FFFF;
    r = 32'h0;
    flt = 1'b0;
    case (f)
      3'b000: r = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b100: r = b;
      3'b001: if (off % 2 != 0) flt = 1'b1; else r = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b101: if (off % 2 != 0) flt = 1'b1; else r = h;
      3'b010: if (off != 0) flt = 1'b1; else r = d;
      default: flt = 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_rw = 1'b0; m_fault = 1'b0; m_dc = 1'b0;
    m_rd = 5'd0; m_wb = 32'h0; m_cnt = 64'h0;
  endtask

  task automatic model_edge();
    logic [31:0] ld;
    bit lf, is_fault;
    if (flush) begin
      m_valid = 1'b0; m_rw = 1'b0; m_fault = 1'b0; m_dc = 1'b0;
      m_rd = 5'd0; m_wb = 32'h0;
    end else if (!stall) begin
      ref_load(f3, alu, rdata, ld, lf);
      is_fault = valid_in && crt[0] && lf;
      m_valid = valid_in;
      m_rd = inst;
      m_wb = crt[0] ? (lf ? 32'h0 : ld) : alu;
      m_rw = valid_in && crt[1] && (inst != 5'd0) && !is_fault;
      m_fault = is_fault;
      m_dc = !valid_in;
      if (valid_in) m_cnt = m_cnt + 64'd1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {63'd0, valid_out}, {63'd0, m_valid});
    check({tag, ".regwr"}, {63'd0, reg_write_out}, {63'd0, m_rw});
    check({tag, ".fault"}, {63'd0, load_fault_out}, {63'd0, m_fault});
    check({tag, ".retired"}, retired_out, m_cnt);
    if (!m_dc) begin
      check({tag, ".rd"}, {59'd0, rd_out}, {59'd0, m_rd});
      check({tag, ".wb"}, {32'd0, wb_data_out}, {32'd0, m_wb});
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  logic [2:0]  ld_f3  [8] = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b001, 3'b101, 3'b101, 3'b010};
  logic [1:0]  ld_off [8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd2, 2'd0};
  logic [31:0] ld_exp [8] = '{32'hFFFF_FF82, 32'h0000_007F, 32'h0000_0080, 32'h0000_00F1,
                              32'hFFFF_80F1, 32'h0000_7F82, 32'h0000_80F1, 32'h80F1_7F82};
  logic [2:0]  ft_f3  [3] = '{3'b010, 3'b001, 3'b011};
  logic [1:0]  ft_off [3] = '{2'd2, 2'd1, 2'd0};

  initial begin
    rst = 1'b0; valid_in = 1'b0; stall = 1'b0; flush = 1'b0; crt = 2'b00; f3 = 3'b000;
    alu = 32'h0; rdata = 32'h0; inst = 5'd0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // ALU write-back and the x0 suppression.
    valid_in = 1'b1; crt = 2'b10; alu = 32'h0000_1234; inst = 5'd5;
    tick("alu");
    check("alu.regwr_const", {63'd0, reg_write_out}, 64'd1);
    check("alu.wb_const", {32'd0, wb_data_out}, 64'h0000_1234);
    check("alu.cnt_const", retired_out, 64'd1);
    inst = 5'd0;
    tick("alu_x0");
    check("alu_x0.regwr_const", {63'd0, reg_write_out}, 64'd0);
    check("alu_x0.cnt_const", retired_out, 64'd2);

    // Load extraction sweep over one word.
    rdata = 32'h80F1_7F82; crt = 2'b11; inst = 5'd7;
    for (int i = 0; i < 8; i++) begin
      f3 = ld_f3[i]; alu = 32'h0000_1000 + {30'd0, ld_off[i]};
      tick($sformatf("load%0d", i));
      check($sformatf("load%0d.const", i), {32'd0, wb_data_out}, {32'd0, ld_exp[i]});
    end

    // Misaligned and reserved loads.
    for (int i = 0; i < 3; i++) begin
      f3 = ft_f3[i]; alu = 32'h0000_2000 + {30'd0, ft_off[i]};
      tick($sformatf("fault%0d", i));
      check($sformatf("fault%0d.flag", i), {63'd0, load_fault_out}, 64'd1);
      check($sformatf("fault%0d.wb0", i), {32'd0, wb_data_out}, 64'd0);
    end

    // Stall for three cycles with changing inputs, then flush under stall.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu = $urandom; inst = 5'($urandom); crt = 2'($urandom); f3 = 3'($urandom);
      tick($sformatf("stall%0d", i));
    end
    check("stall.fault_held", {63'd0, load_fault_out}, 64'd1);
    flush = 1'b1;
    tick("flush_stall");
    stall = 1'b0; flush = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      crt = 2'($urandom); f3 = 3'($urandom); alu = $urandom;
      rdata = $urandom; inst = 5'($urandom);
      tick($sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-stream.
    valid_in = 1'b1; stall = 1'b0; flush = 1'b0; crt = 2'b10; alu = 32'hCAFE_0001; inst = 5'd9;
    tick("pre_rst0");
    tick("pre_rst1");
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst.cnt", retired_out, 64'd0);
    tick("post_rst");

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.retired_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    check("wrap.preload", retired_out, m_cnt);
    valid_in = 1'b1; inst = 5'd3;
    tick("wrap");
    check("wrap.zero", retired_out, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
